// File: rtl/strat_pkg.sv
// Shared definitions for the strategy/order path: side encoding, order-gate
// FSM state encoding and default datapath widths.
`timescale 1ns/1ps
package strat_pkg;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam int DEF_W  = 32;
  localparam int DEF_QW = 16;
  localparam int DEF_PW = 24;

endpackage

// File: rtl/sat_acc.sv
// Signed accumulator that adds or subtracts an unsigned amount per enabled
// cycle and clamps at the PW-bit signed extremes instead of wrapping.
`timescale 1ns/1ps
module sat_acc #(
  parameter int PW = 24,
  parameter int QW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sub,
  input  logic [QW-1:0]        amt,
  output logic signed [PW-1:0] acc
);

  localparam logic signed [PW:0] MAX_V = {2'b00, {(PW-1){1'b1}}};
  localparam logic signed [PW:0] MIN_V = {2'b11, {(PW-1){1'b0}}};

  logic signed [PW:0] acc_x;
  logic signed [PW:0] amt_x;
  logic signed [PW:0] sum;
  logic signed [PW-1:0] acc_nxt;

  // One extra bit of headroom holds any single step without overflow.
  always_comb begin
    acc_x = {acc[PW-1], acc};
    amt_x = {{(PW+1-QW){1'b0}}, amt};
    sum   = sub ? (acc_x - amt_x) : (acc_x + amt_x);
    if (sum > MAX_V)
      acc_nxt = MAX_V[PW-1:0];
    else if (sum < MIN_V)
      acc_nxt = MIN_V[PW-1:0];
    else
      acc_nxt = sum[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (en)
      acc <= acc_nxt;
  end

endmodule

// File: rtl/order_gate.sv
// Risk gate between the strategy decision and the order encoder. Handshake:
// ord_valid stays high with stable ord_* until an edge with ord_ready high.
`timescale 1ns/1ps
module order_gate
  import strat_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int QW       = DEF_QW,
  parameter int PW       = DEF_PW,
  parameter int COOLDOWN = 8,
  parameter int MAX_OUT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_valid,
  input  logic                 sig_buy,
  input  logic                 sig_sell,
  input  logic [W-1:0]         bid_px0,
  input  logic [W-1:0]         ask_px0,
  input  logic [QW-1:0]        order_qty,
  input  logic [PW-2:0]        pos_limit,
  input  logic                 kill,
  output logic                 ord_valid,
  input  logic                 ord_ready,
  output logic                 ord_side,
  output logic [W-1:0]         ord_px,
  output logic [QW-1:0]        ord_qty,
  input  logic                 ack_valid,
  input  logic                 ack_side,
  input  logic [QW-1:0]        ack_fill_qty,
  output logic signed [PW-1:0] position,
  output logic [3:0]           outstanding,
  output logic [15:0]          reject_cnt,
  output state_t               dbg_state
);

  // Cooldown counter is 8 bits, so COOLDOWN may range 0..256.
  localparam logic [7:0] CD_LOAD = (COOLDOWN > 0) ? 8'(COOLDOWN - 1) : 8'd0;

  state_t state, state_nxt;
  logic [7:0] cd_cnt;

  logic signed [PW:0] pos_x, qty_x, lim_x;
  logic buy_over, sell_over, limit_hit;
  logic accept, reject, hs, ack_eff;

  always_comb begin
    pos_x     = {position[PW-1], position};
    qty_x     = {{(PW+1-QW){1'b0}}, order_qty};
    lim_x     = {2'b00, pos_limit};
    buy_over  = (pos_x + qty_x) > lim_x;
    sell_over = (pos_x - qty_x) < -lim_x;
    limit_hit = sig_buy ? buy_over : sell_over;
    accept    = (state == ST_IDLE) && sig_valid && (sig_buy ^ sig_sell) && !kill &&
                (outstanding != 4'(MAX_OUT)) && !limit_hit;
    // Any flagged decision that is not taken counts, whatever the state.
    reject    = sig_valid && (sig_buy || sig_sell) && !accept;
    hs        = (state == ST_PRESENT) && ord_ready;
    ack_eff   = ack_valid && (outstanding != 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept) state_nxt = ST_PRESENT;
      ST_PRESENT:  if (hs) state_nxt = (COOLDOWN == 0) ? ST_IDLE : ST_COOLDOWN;
      ST_COOLDOWN: if (cd_cnt == 8'd0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ord_valid = (state == ST_PRESENT);
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_cnt      <= 8'd0;
      ord_side    <= 1'b0;
      ord_px      <= '0;
      ord_qty     <= '0;
      outstanding <= 4'd0;
      reject_cnt  <= 16'd0;
    end else begin
      if (hs)
        cd_cnt <= CD_LOAD;
      else if (state == ST_COOLDOWN && cd_cnt != 8'd0)
        cd_cnt <= cd_cnt - 8'd1;

      if (accept) begin
        ord_side <= sig_buy ? SIDE_BUY : SIDE_SELL;
        ord_px   <= sig_buy ? ask_px0 : bid_px0;
        ord_qty  <= order_qty;
      end

      if (hs && !ack_eff)
        outstanding <= outstanding + 4'd1;
      else if (!hs && ack_eff)
        outstanding <= outstanding - 4'd1;

      if (reject && reject_cnt != 16'hFFFF)
        reject_cnt <= reject_cnt + 16'd1;
    end
  end

  sat_acc #(.PW(PW), .QW(QW)) u_pos (
    .clk (clk),
    .rst (rst),
    .en  (ack_eff),
    .sub (ack_side == SIDE_SELL),
    .amt (ack_fill_qty),
    .acc (position)
  );

endmodule

// File: tb/tb_order_gate.sv
// Directed bench for order_gate: orders are checked by a scoreboard monitor,
// counters and position by direct checks after each scenario.
`timescale 1ns/1ps
module tb_order_gate;
  import strat_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_valid = 0, sig_buy = 0, sig_sell = 0;
  logic [31:0] bid_px0 = 0, ask_px0 = 0;
  logic [15:0] order_qty = 0;
  logic [22:0] pos_limit = 0;
  logic kill = 0;
  logic ord_valid, ord_ready = 0, ord_side;
  logic [31:0] ord_px;
  logic [15:0] ord_qty;
  logic ack_valid = 0, ack_side = 0;
  logic [15:0] ack_fill_qty = 0;
  logic signed [23:0] position;
  logic [23:0] pos_u;
  logic [3:0] outstanding;
  logic [15:0] reject_cnt;
  state_t dbg_state;

  logic [48:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  assign pos_u = position;

  order_gate #(.COOLDOWN(8), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .sig_valid(sig_valid), .sig_buy(sig_buy), .sig_sell(sig_sell),
    .bid_px0(bid_px0), .ask_px0(ask_px0), .order_qty(order_qty), .pos_limit(pos_limit),
    .kill(kill), .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_side(ord_side),
    .ord_px(ord_px), .ord_qty(ord_qty), .ack_valid(ack_valid), .ack_side(ack_side),
    .ack_fill_qty(ack_fill_qty), .position(position), .outstanding(outstanding),
    .reject_cnt(reject_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic decide(input logic b, input logic s, input logic [15:0] q);
    sig_valid = 1; sig_buy = b; sig_sell = s; order_qty = q;
    bid_px0 = 32'd10000; ask_px0 = 32'd10010;
    tick(1);
    sig_valid = 0; sig_buy = 0; sig_sell = 0;
  endtask

  task automatic ack(input logic side, input logic [15:0] q);
    ack_valid = 1; ack_side = side; ack_fill_qty = q;
    tick(1);
    ack_valid = 0;
  endtask

  // Monitor: every presented order must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && ord_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_order: got side=%0b px=%0d qty=%0d expected none",
                 ord_side, ord_px, ord_qty);
      end else begin
        chk("order_fields", {15'd0, ord_side, ord_px, ord_qty}, {15'd0, exp_q[0]});
        if (ord_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    tick(2);
    chk("rst_ord_valid", ord_valid, 0);
    chk("rst_ord_px", ord_px, 0);
    chk("rst_position", pos_u, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_reject_cnt", reject_cnt, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 0;
    tick(1);

    // Buy accepted with ready held high
    pos_limit = 23'd100; ord_ready = 1;
    exp_q.push_back({1'b1, 32'd10010, 16'd5});
    decide(1, 0, 16'd5);
    chk("buy_valid", ord_valid, 1);
    tick(1);
    chk("buy_hs_valid_low", ord_valid, 0);
    chk("buy_outstanding", outstanding, 1);
    tick(8);
    chk("cooldown_done", dbg_state, ST_IDLE);

    // Fill, then position limit
    ack(SIDE_BUY, 16'd5);
    chk("fill_position", pos_u, 24'd5);
    chk("fill_outstanding", outstanding, 0);
    pos_limit = 23'd8;
    decide(1, 0, 16'd5);
    chk("limit_reject_cnt", reject_cnt, 1);
    chk("limit_no_order", ord_valid, 0);

    // Backpressure on a sell, decision dropped while presenting
    pos_limit = 23'd100; ord_ready = 0;
    exp_q.push_back({1'b0, 32'd10000, 16'd7});
    decide(0, 1, 16'd7);
    decide(1, 0, 16'd9);
    tick(2);
    chk("bp_valid_held", ord_valid, 1);
    chk("bp_reject_cnt", reject_cnt, 2);
    ord_ready = 1;
    tick(1);
    chk("bp_hs_valid_low", ord_valid, 0);
    chk("bp_outstanding", outstanding, 1);
    tick(7);
    decide(1, 0, 16'd3);
    chk("cooldown_8_dropped", reject_cnt, 3);
    exp_q.push_back({1'b1, 32'd10010, 16'd3});
    decide(1, 0, 16'd3);
    chk("cooldown_9_valid", ord_valid, 1);
    tick(1);
    chk("two_outstanding", outstanding, 2);
    tick(9);

    // Both flags, kill, outstanding cap
    decide(1, 1, 16'd1);
    chk("both_flags_reject", reject_cnt, 4);
    kill = 1;
    decide(1, 0, 16'd1);
    kill = 0;
    chk("kill_reject", reject_cnt, 5);
    decide(1, 0, 16'd1);
    chk("cap_reject", reject_cnt, 6);
    chk("cap_no_order", ord_valid, 0);
    ack(SIDE_SELL, 16'd7);
    chk("sell_fill_position", pos_u, 24'hFFFFFE);
    chk("sell_fill_outstanding", outstanding, 1);

    // Kill during PRESENT; ack on the handshake edge
    ord_ready = 0;
    exp_q.push_back({1'b1, 32'd10010, 16'd2});
    decide(1, 0, 16'd2);
    kill = 1;
    tick(1);
    ord_ready = 1; ack_valid = 1; ack_side = SIDE_BUY; ack_fill_qty = 16'd3;
    tick(1);
    ack_valid = 0; kill = 0;
    chk("kill_present_done", ord_valid, 0);
    chk("hs_ack_outstanding", outstanding, 1);
    chk("hs_ack_position", pos_u, 24'd1);
    tick(9);
    ack(SIDE_BUY, 16'd0);
    chk("zero_fill_outstanding", outstanding, 0);
    chk("zero_fill_position", pos_u, 24'd1);
    ack(SIDE_BUY, 16'd50);
    chk("ack_at_zero_outstanding", outstanding, 0);
    chk("ack_at_zero_position", pos_u, 24'd1);
    decide(0, 0, 16'd1);
    chk("no_flags_silent", reject_cnt, 6);

    // Sell limit boundary: -11 rejected, -10 allowed
    pos_limit = 23'd10;
    decide(0, 1, 16'd12);
    chk("sell_limit_reject", reject_cnt, 7);
    exp_q.push_back({1'b0, 32'd10000, 16'd11});
    decide(0, 1, 16'd11);
    tick(1);
    chk("sell_edge_outstanding", outstanding, 1);
    chk("sell_edge_reject_cnt", reject_cnt, 7);
    tick(9);

    // Async reset while presenting
    ord_ready = 0;
    exp_q.push_back({1'b1, 32'd10010, 16'd1});
    decide(1, 0, 16'd1);
    chk("pre_reset_valid", ord_valid, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", ord_valid, 0);
    chk("async_rst_position", pos_u, 0);
    chk("async_rst_outstanding", outstanding, 0);
    chk("async_rst_reject_cnt", reject_cnt, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 0;
    ord_ready = 1; pos_limit = 23'd100;
    exp_q.push_back({1'b1, 32'd10010, 16'd4});
    decide(1, 0, 16'd4);
    chk("post_rst_valid", ord_valid, 1);
    tick(1);
    chk("post_rst_outstanding", outstanding, 1);
    tick(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/order_gate.md
# order_gate

Order gate sits directly downstream of `strat_decide`. It takes each registered buy/sell decision together with the top-of-book prices and applies the risk checks: kill switch, position limit, outstanding-order cap and inter-order cooldown. A decision that passes becomes one aggressive order, held on a valid/ready interface to the order encoder. The block also tracks net position and the outstanding-order count from exchange acks.

## Interface
- `W`, 32: price width
- `QW`, 16: quantity width
- `PW`, 24: signed position width
- `COOLDOWN`, 8: idle cycles forced after each accepted order (0 allowed)
- `MAX_OUT`, 4: maximum un-acked orders (1..15)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `sig_valid`  in  1  decision strobe (`strat_decide` out_valid)
- `sig_buy`, `sig_sell`  in  1 each  decision flags
- `bid_px0`, `ask_px0`  in  W  top of book, sampled with `sig_valid`
- `order_qty`  in  QW  order size, sampled with `sig_valid`
- `pos_limit`  in  PW-1  absolute position limit (unsigned)
- `kill`  in  1  level kill switch
- `ord_valid`  out  1  order presented
- `ord_ready`  in  1  encoder accepts
- `ord_side`  out  1  1 = buy, 0 = sell
- `ord_px`, `ord_qty`  out  W, QW  order price and quantity
- `ack_valid`  in  1  exchange ack, one per order
- `ack_side`, `ack_fill_qty`  in  1, QW  side and filled qty (0 = reject/cancel)
- `position`  out  PW  signed net position
- `outstanding`  out  4  un-acked order count
- `reject_cnt`  out  16  saturating count of dropped decisions

## Operation
- States are IDLE, PRESENT and COOLDOWN.
- **IDLE:** on `sig_valid`, evaluate the checks in this order:
  - `sig_buy` and `sig_sell` both set: reject.
  - Neither flag set: drop silently, no count.
  - `kill` high: reject.
  - `outstanding == MAX_OUT`: reject.
  - Buy with `position + order_qty > pos_limit`: reject.
  - Sell with `position - order_qty < -pos_limit`: reject.
  - Otherwise latch the order and go to PRESENT.
- **Order fields:** buy uses `ord_px = ask_px0`; sell uses `ord_px = bid_px0`; `ord_qty = order_qty`.
- **Position arithmetic:** the limit compare is done at PW+1 bits signed, so it never overflows.
- **PRESENT:** `ord_valid` is 1 and all `ord_*` fields are stable.
  - On `ord_ready`: handshake. `outstanding` increments, then go to COOLDOWN, or to IDLE if `COOLDOWN == 0`.
  - `kill` does not retract a presented order.
- **COOLDOWN:** a counter loads `COOLDOWN-1` on entry and decrements each cycle. Return to IDLE in the cycle after it reaches 0.
- **Dropped decisions:** any `sig_valid` with at least one flag set that arrives outside IDLE is dropped and `reject_cnt` increments.
- **reject_cnt:** saturates at 0xFFFF.
- **Ack, in any state:**
  - `outstanding` decrements, but is never decremented below 0. An ack while `outstanding == 0` has no effect at all.
  - `position` adds `ack_fill_qty` for a buy and subtracts it for a sell, saturating at the PW-bit signed extremes.
- **Simultaneous handshake and ack:** `outstanding` is unchanged.
- **Limit-check timing:** the check uses the registered `position`. An ack in the same cycle as `sig_valid` does not affect that check.

## Timing
- **Reset values:** state IDLE, `ord_valid` 0, `ord_side` 0, `ord_px` 0, `ord_qty` 0, `position` 0, `outstanding` 0, `reject_cnt` 0, cooldown counter 0.
- **Decision to order:** `sig_valid` at edge N leads to `ord_valid` = 1 after edge N+1 (one-cycle latency, registered outputs).
- **Handshake:** completes on an edge where `ord_valid && ord_ready`. `ord_valid` is 0 after that edge.
- **Next order:** with `COOLDOWN = C`, the earliest next accepted `sig_valid` is C+1 edges after the handshake edge.
- **Reset mid-operation:** a pending order is discarded and `ord_valid` drops asynchronously. Counters and position clear.

## Structure
- Shared package `strat_pkg` holds:
  - side constants `SIDE_BUY = 1`, `SIDE_SELL = 0`;
  - the state encoding (IDLE = 0, PRESENT = 1, COOLDOWN = 2);
  - the default widths W, QW and PW.
- Single module, plus one natural sub-module `sat_acc`: a signed saturating add/sub accumulator, used for `position`.

## Test plan
- **Buy accepted:** bid=10000, ask=10010, `sig_buy` pulse, qty=5, pos_limit=100, `ord_ready` held 1 → next cycle `ord_valid` = 1, side = 1, px = 10010, qty = 5; one-cycle handshake; `outstanding` = 1.
- **Fill and position limit:**
  - Ack buy fill=5 → `position` = 5, `outstanding` = 0.
  - Set pos_limit=8, then a buy of qty=5 → rejected, `reject_cnt` = 1, no `ord_valid`.
- **Backpressure and cooldown:**
  - Sell at bid=10000 with `ord_ready` = 0 for 3 cycles → `ord_valid` and fields stable; a `sig_valid` arriving meanwhile increments `reject_cnt`.
  - After the handshake with COOLDOWN=8, a decision 8 edges later is dropped; one at 9 edges is accepted.
- **Both flags and kill:** buy and sell set together → reject; `kill` = 1 with a valid buy → reject; `kill` asserted during PRESENT → order still completes.
- **Outstanding cap and ack edges:**
  - MAX_OUT=2: two orders with no acks, then a third → rejected.
  - An ack in the same cycle as a handshake → `outstanding` unchanged.
  - An ack at `outstanding == 0` → stays 0 and `position` does not change.
- **Async reset:** assert `rst` between edges while in PRESENT → `ord_valid`, `position` and `outstanding` go to 0 immediately; after release a buy is accepted normally.
